// File: rtl/cu_mem_arbiter.sv
// Single-port SRAM arbiter shared by the CU fetch (IF) and data (MEM) paths.
// MEM has priority; a saturating counter forces an IF grant on starvation.
module cu_mem_arbiter #(
  parameter int unsigned SRAM_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        soc_clk,
  input  logic        MEM_reset_reg,
  input  logic        if_req,
  input  logic [6:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [6:0]  mem_addr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        sram_en,
  output logic        sram_we,
  output logic [6:0]  sram_addr,
  output logic [3:0]  sram_be,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        is_if;
    logic        we;
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } acc_t;

  localparam logic [2:0] LAT_M1 = 3'(SRAM_LAT - 1);
  localparam logic [2:0] SLIM   = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  starve_q, starve_d;
  logic        arb_pt, any_req;
  logic        mem_win, if_win;

  logic        if_gnt_d, if_rvalid_d;
  logic [31:0] if_rdata_d;
  logic        mem_gnt_d, mem_rvalid_d;
  logic [31:0] mem_rdata_d;
  logic        sram_en_d, sram_we_d;
  logic [6:0]  sram_addr_d;
  logic [3:0]  sram_be_d;
  logic [31:0] sram_wdata_d;
  logic        busy_d;

  always_comb begin
    any_req = if_req | mem_req;
    arb_pt  = (state_q == IDLE) || (state_q == RESP);
    mem_win = mem_req && !(if_req && (starve_q == SLIM));
    if_win  = if_req && !mem_win;

    state_d  = state_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    starve_d = starve_q;

    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (any_req) begin
          state_d = ACCESS;
          unique case (1'b1)
            mem_win: begin
              acc_d.is_if = 1'b0;
              acc_d.we    = mem_we;
              acc_d.addr  = mem_addr;
              acc_d.be    = mem_be;
              acc_d.wdata = mem_wdata;
            end
            if_win: begin
              acc_d.is_if = 1'b1;
              acc_d.we    = 1'b0;
              acc_d.addr  = if_addr;
              acc_d.be    = 4'hF;
              acc_d.wdata = '0;
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        state_d = WAIT;
        wcnt_d  = LAT_M1;
      end
      WAIT: begin
        if (wcnt_q == 3'd0) state_d = RESP;
        else wcnt_d = wcnt_q - 3'd1;
      end
    endcase

    // Starvation count only moves at arbitration points.
    if (arb_pt) begin
      if (!if_req || if_win) starve_d = 3'd0;
      else if (mem_win && starve_q != SLIM)
        starve_d = starve_q + 3'd1;
    end

    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_rdata_d   = '0;
    mem_gnt_d    = 1'b0;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = '0;
    sram_en_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = '0;
    sram_be_d    = '0;
    sram_wdata_d = '0;
    busy_d       = (state_d != IDLE);

    unique case (state_d)
      ACCESS: begin
        if_gnt_d     = acc_d.is_if;
        mem_gnt_d    = !acc_d.is_if;
        sram_en_d    = 1'b1;
        sram_we_d    = acc_d.we;
        sram_addr_d  = acc_d.addr;
        sram_be_d    = acc_d.be;
        sram_wdata_d = acc_d.wdata;
      end
      RESP: begin
        if_rvalid_d  = acc_q.is_if;
        mem_rvalid_d = !acc_q.is_if;
        if (acc_q.is_if) if_rdata_d = sram_rdata;
        else if (!acc_q.we) mem_rdata_d = sram_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge soc_clk or posedge MEM_reset_reg) begin
    if (MEM_reset_reg) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      wcnt_q     <= '0;
      starve_q   <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      mem_gnt    <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_be    <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wcnt_q     <= wcnt_d;
      starve_q   <= starve_d;
      if_gnt     <= if_gnt_d;
      if_rvalid  <= if_rvalid_d;
      if_rdata   <= if_rdata_d;
      mem_gnt    <= mem_gnt_d;
      mem_rvalid <= mem_rvalid_d;
      mem_rdata  <= mem_rdata_d;
      sram_en    <= sram_en_d;
      sram_we    <= sram_we_d;
      sram_addr  <= sram_addr_d;
      sram_be    <= sram_be_d;
      sram_wdata <= sram_wdata_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_cu_mem_arbiter.sv
// Directed bench for cu_mem_arbiter: one instance at SRAM_LAT=1,
// a second at SRAM_LAT=3 for the long-latency read.
module tb_cu_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, mem_req, mem_we;
  logic [6:0]  if_addr, mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, sram_rdata;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid;
  logic [31:0] if_rdata, mem_rdata, sram_wdata;
  logic        sram_en, sram_we, busy;
  logic [6:0]  sram_addr;
  logic [3:0]  sram_be;

  logic        if_req3, mem_req3, mem_we3;
  logic [6:0]  if_addr3, mem_addr3;
  logic [3:0]  mem_be3;
  logic [31:0] mem_wdata3, sram_rdata3;
  logic        if_gnt3, if_rvalid3, mem_gnt3, mem_rvalid3;
  logic [31:0] if_rdata3, mem_rdata3, sram_wdata3;
  logic        sram_en3, sram_we3, busy3;
  logic [6:0]  sram_addr3;
  logic [3:0]  sram_be3;

  int n_chk  = 0;
  int n_fail = 0;

  cu_mem_arbiter #(.SRAM_LAT(1), .STARVE_LIMIT(3)) dut (
    .soc_clk(clk), .MEM_reset_reg(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .busy(busy)
  );

  cu_mem_arbiter #(.SRAM_LAT(3), .STARVE_LIMIT(3)) dut3 (
    .soc_clk(clk), .MEM_reset_reg(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_be(mem_be3), .mem_wdata(mem_wdata3), .mem_gnt(mem_gnt3),
    .mem_rvalid(mem_rvalid3), .mem_rdata(mem_rdata3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_addr(sram_addr3),
    .sram_be(sram_be3), .sram_wdata(sram_wdata3),
    .sram_rdata(sram_rdata3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [5];
    logic [1:0] exp_order [5];
    int ng;
    logic seen;

    exp_order[0] = 2'd1; exp_order[1] = 2'd1;
    exp_order[2] = 2'd1; exp_order[3] = 2'd2;
    exp_order[4] = 2'd1;

    rst = 1'b1;
    if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
    mem_addr = 0; mem_be = 0; mem_wdata = 0; sram_rdata = 0;
    if_req3 = 0; if_addr3 = 0; mem_req3 = 0; mem_we3 = 0;
    mem_addr3 = 0; mem_be3 = 0; mem_wdata3 = 0; sram_rdata3 = 0;

    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_mem_rvalid", mem_rvalid, 0);
    chk("rst_busy3", busy3, 0);
    rst = 1'b0;
    step();

    // IF read of 0x10
    if_req = 1; if_addr = 7'h10; sram_rdata = 32'hDEADBEEF;
    step();
    chk("if1_gnt", if_gnt, 1);
    chk("if1_mem_gnt", mem_gnt, 0);
    chk("if1_en", sram_en, 1);
    chk("if1_addr", sram_addr, 32'h10);
    chk("if1_we", sram_we, 0);
    chk("if1_be", sram_be, 32'hF);
    chk("if1_busy", busy, 1);
    if_req = 0;
    step();
    chk("if1_wait_en", sram_en, 0);
    chk("if1_wait_rv", if_rvalid, 0);
    step();
    chk("if1_rvalid", if_rvalid, 1);
    chk("if1_rdata", if_rdata, 32'hDEADBEEF);
    chk("if1_mem_rv", mem_rvalid, 0);
    step();
    chk("if1_idle", busy, 0);
    chk("if1_rv_off", if_rvalid, 0);

    // MEM write to top address
    mem_req = 1; mem_we = 1; mem_addr = 7'h7F;
    mem_be = 4'b0011; mem_wdata = 32'h12345678;
    step();
    chk("wr_gnt", mem_gnt, 1);
    chk("wr_if_gnt", if_gnt, 0);
    chk("wr_en", sram_en, 1);
    chk("wr_we", sram_we, 1);
    chk("wr_addr", sram_addr, 32'h7F);
    chk("wr_be", sram_be, 32'h3);
    chk("wr_wdata", sram_wdata, 32'h12345678);
    mem_req = 0; mem_we = 0; mem_wdata = 32'hFFFF0000;
    step();
    chk("wr_wait_en", sram_en, 0);
    step();
    chk("wr_rvalid", mem_rvalid, 1);
    chk("wr_rdata", mem_rdata, 0);
    step();
    chk("wr_idle", busy, 0);

    // simultaneous requests
    if_req = 1; if_addr = 7'h22;
    mem_req = 1; mem_we = 0; mem_addr = 7'h33;
    sram_rdata = 32'hA5A50001;
    step();
    chk("both_mem_gnt", mem_gnt, 1);
    chk("both_if_gnt0", if_gnt, 0);
    chk("both_addr", sram_addr, 32'h33);
    mem_req = 0;
    step();
    step();
    chk("both_mem_rv", mem_rvalid, 1);
    chk("both_mem_rd", mem_rdata, 32'hA5A50001);
    chk("both_if_gnt1", if_gnt, 0);
    sram_rdata = 32'h0BADF00D;
    step();
    chk("both_if_gnt", if_gnt, 1);
    chk("both_if_addr", sram_addr, 32'h22);
    chk("both_no_idle", busy, 1);
    if_req = 0;
    step();
    step();
    chk("both_if_rv", if_rvalid, 1);
    chk("both_if_rd", if_rdata, 32'h0BADF00D);
    step();
    chk("both_idle", busy, 0);

    // starvation guard: 1=MEM, 2=IF
    if_req = 1; if_addr = 7'h01;
    mem_req = 1; mem_we = 0; mem_addr = 7'h02;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      step();
      chk("stv_excl", {31'd0, if_gnt & mem_gnt}, 0);
      if (mem_gnt) begin order[ng] = 2'd1; ng++; end
      else if (if_gnt) begin order[ng] = 2'd2; ng++; end
    end
    if_req = 0; mem_req = 0;
    chk("stv_count", ng, 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("stv_order%0d", k), {30'd0, order[k]},
          {30'd0, exp_order[k]});
    for (int c = 0; c < 10 && busy; c++) step();
    chk("stv_idle", busy, 0);

    // reset during WAIT of a read
    mem_req = 1; mem_we = 0; mem_addr = 7'h44;
    sram_rdata = 32'h44444444;
    step();
    chk("rw_gnt", mem_gnt, 1);
    mem_req = 0;
    step();
    chk("rw_in_wait", busy, 1);
    rst = 1;
    #1;
    chk("rw_busy0", busy, 0);
    chk("rw_en0", sram_en, 0);
    chk("rw_rv0", mem_rvalid, 0);
    step(); step();
    rst = 0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (mem_rvalid) seen = 1;
    end
    chk("rw_no_rvalid", seen, 0);
    mem_req = 1; mem_addr = 7'h45; sram_rdata = 32'hCAFE0045;
    step();
    chk("rw2_gnt", mem_gnt, 1);
    chk("rw2_addr", sram_addr, 32'h45);
    mem_req = 0;
    step();
    step();
    chk("rw2_rv", mem_rvalid, 1);
    chk("rw2_rd", mem_rdata, 32'hCAFE0045);
    step();

    // SRAM_LAT=3 read of 0x05
    mem_req3 = 1; mem_we3 = 0; mem_addr3 = 7'h05;
    step();
    chk("l3_gnt", mem_gnt3, 1);
    chk("l3_en", sram_en3, 1);
    chk("l3_addr", sram_addr3, 32'h05);
    mem_req3 = 0; sram_rdata3 = 32'h11110001;
    step();
    chk("l3_w1_en", sram_en3, 0);
    chk("l3_w1_rv", mem_rvalid3, 0);
    sram_rdata3 = 32'h22220002;
    step();
    chk("l3_w2_rv", mem_rvalid3, 0);
    sram_rdata3 = 32'h33330003;
    step();
    chk("l3_w3_rv", mem_rvalid3, 0);
    chk("l3_w3_busy", busy3, 1);
    sram_rdata3 = 32'h44440004;
    step();
    chk("l3_rv", mem_rvalid3, 1);
    chk("l3_rd", mem_rdata3, 32'h44440004);
    sram_rdata3 = 32'h55550005;
    step();
    chk("l3_rv_off", mem_rvalid3, 0);
    chk("l3_idle", busy3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
